// File: rtl/game_sequencer.sv
// Game-flow controller for the road-crossing game: sequences IDLE/PLAY/HIT/WIN
// phases, owns the 0..99 level counter, issues player-reset pulses and derives
// the level-dependent car move tick from frame starts.
// Optional feature macro: LIVES_EN (adds a lives counter, the OVER state and o_lives).
module game_sequencer #(
  parameter int unsigned GOAL_ROW    = 1,
  parameter int unsigned BASE_DIV    = 12,
  parameter int unsigned MIN_DIV     = 2,
  parameter int unsigned LEVEL_SHIFT = 3,
  parameter int unsigned HOLD_FRAMES = 60,
  parameter int unsigned FLASH_BIT   = 3
) (
  input  logic       i_Clk,
  input  logic       i_Rst_n,
  input  logic       i_frame_start,
  input  logic       i_start,
  input  logic [3:0] i_player_y,
  input  logic       i_collision,
  output logic [6:0] o_level,
  output logic [2:0] o_state,
  output logic       o_player_reset,
  output logic       o_freeze,
  output logic       o_move_tick,
`ifdef LIVES_EN
  output logic       o_flash,
  output logic [1:0] o_lives
`else
  output logic       o_flash
`endif
);

  localparam int unsigned LEVEL_W = 7;
  localparam int unsigned DIV_W   = 4;
  localparam int unsigned HOLD_W  = 7;
  localparam int unsigned CALC_W  = 8;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PLAY = 3'd1,
    S_HIT  = 3'd2,
    S_WIN  = 3'd3,
    S_OVER = 3'd4
  } state_t;

  state_t              state;
  logic                start_q;
  logic [DIV_W-1:0]    div_cnt;
  logic [HOLD_W-1:0]   hold_cnt;

  logic                start_ev;
  logic [CALC_W-1:0]   lvl_shifted;
  logic signed [CALC_W-1:0] div_raw;
  logic [CALC_W-1:0]   div_eff;
  logic [DIV_W-1:0]    div_last;
  logic                frame_wrap;
  logic                hold_done;
  logic [HOLD_W-1:0]   hold_inc;

  assign o_state = state;

  // Start button edge detect; start_q resets high so a held button is ignored.
  assign start_ev = i_start & ~start_q;

  // Move-tick period: base divider shrinks with level, clamped to the minimum.
  assign lvl_shifted = CALC_W'(o_level) >> LEVEL_SHIFT;
  assign div_raw     = $signed(CALC_W'(BASE_DIV) - lvl_shifted);
  assign div_eff     = (div_raw < $signed(CALC_W'(MIN_DIV))) ? CALC_W'(MIN_DIV)
                                                             : $unsigned(div_raw);
  assign div_last    = DIV_W'(div_eff - CALC_W'(1));
  assign frame_wrap  = (div_cnt == div_last);

  // Hold timing for the HIT/WIN phases.
  assign hold_inc  = hold_cnt + HOLD_W'(1);
  assign hold_done = (hold_cnt == HOLD_W'(HOLD_FRAMES - 1));

  // Game-flow state machine with registered outputs.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      state          <= S_IDLE;
      start_q        <= 1'b1;
      div_cnt        <= '0;
      hold_cnt       <= '0;
      o_level        <= '0;
      o_player_reset <= 1'b0;
      o_freeze       <= 1'b1;
      o_move_tick    <= 1'b0;
      o_flash        <= 1'b0;
`ifdef LIVES_EN
      o_lives        <= 2'd3;
`endif
    end else begin
      start_q        <= i_start;
      o_player_reset <= 1'b0;
      o_move_tick    <= 1'b0;

      case (state)
        S_IDLE: begin
          o_freeze <= 1'b1;
          o_flash  <= 1'b0;
          if (start_ev) begin
            state          <= S_PLAY;
            o_player_reset <= 1'b1;
            div_cnt        <= '0;
            o_freeze       <= 1'b0;
          end
        end

        S_PLAY: begin
          o_freeze <= 1'b0;
          o_flash  <= 1'b0;
          if (i_frame_start) begin
            if (frame_wrap) begin
              div_cnt     <= '0;
              o_move_tick <= 1'b1;
            end else begin
              div_cnt <= div_cnt + DIV_W'(1);
            end
          end
          if (i_collision) begin
            state    <= S_HIT;
            hold_cnt <= '0;
            o_freeze <= 1'b1;
`ifdef LIVES_EN
            o_lives  <= o_lives - 2'd1;
`endif
          end else if (i_player_y == 4'(GOAL_ROW)) begin
            state    <= S_WIN;
            hold_cnt <= '0;
            o_freeze <= 1'b1;
            o_level  <= (o_level == LEVEL_W'(99)) ? '0 : o_level + LEVEL_W'(1);
          end
        end

        S_HIT, S_WIN: begin
          o_freeze <= 1'b1;
          if (i_frame_start) begin
            if (hold_done) begin
              o_flash <= 1'b0;
`ifdef LIVES_EN
              if (state == S_HIT && o_lives == 2'd0) begin
                state   <= S_OVER;
                o_flash <= 1'b1;
              end else begin
                state          <= S_PLAY;
                o_player_reset <= 1'b1;
                div_cnt        <= '0;
                o_freeze       <= 1'b0;
              end
`else
              if (state == S_HIT) begin
                o_level <= '0;
              end
              state          <= S_PLAY;
              o_player_reset <= 1'b1;
              div_cnt        <= '0;
              o_freeze       <= 1'b0;
`endif
            end else begin
              hold_cnt <= hold_inc;
              o_flash  <= hold_inc[FLASH_BIT];
            end
          end
        end

`ifdef LIVES_EN
        S_OVER: begin
          o_freeze <= 1'b1;
          o_flash  <= 1'b1;
          if (start_ev) begin
            state          <= S_PLAY;
            o_level        <= '0;
            o_lives        <= 2'd3;
            o_player_reset <= 1'b1;
            div_cnt        <= '0;
            o_freeze       <= 1'b0;
            o_flash        <= 1'b0;
          end
        end
`endif

        default: begin
          state    <= S_IDLE;
          o_freeze <= 1'b1;
          o_flash  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_game_sequencer.sv
// Self-checking bench for game_sequencer (default build, LIVES_EN undefined).
module tb_game_sequencer;

  logic       clk = 1'b0;
  logic       rst_n, fs, st, col;
  logic [3:0] py;
  logic [6:0] o_level;
  logic [2:0] o_state;
  logic       o_player_reset, o_freeze, o_move_tick, o_flash;

  always #5 clk = ~clk;

  game_sequencer dut (
    .i_Clk          (clk),
    .i_Rst_n        (rst_n),
    .i_frame_start  (fs),
    .i_start        (st),
    .i_player_y     (py),
    .i_collision    (col),
    .o_level        (o_level),
    .o_state        (o_state),
    .o_player_reset (o_player_reset),
    .o_freeze       (o_freeze),
    .o_move_tick    (o_move_tick),
    .o_flash        (o_flash)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: game rules in plain integer arithmetic.
  int m_state = 0, m_level = 0, m_frames = 0, m_hold = 0, m_startq = 1;
  int m_prst = 0, m_tick = 0, m_flash = 0, m_freeze = 1;

  task automatic model_step(input bit r, input bit f, input bit s, input int y, input bit c);
    int  d;
    bit  ev;
    if (!r) begin
      m_state = 0; m_level = 0; m_frames = 0; m_hold = 0; m_startq = 1;
      m_prst = 0; m_tick = 0; m_flash = 0; m_freeze = 1;
      return;
    end
    ev = s && !m_startq;
    m_startq = s;
    m_prst = 0;
    m_tick = 0;
    case (m_state)
      0: if (ev) begin m_state = 1; m_prst = 1; m_frames = 0; end
      1: begin
        if (f) begin
          d = 12 - m_level / 8;
          if (d < 2) d = 2;
          m_frames = (m_frames + 1) % d;
          m_tick = (m_frames == 0) ? 1 : 0;
        end
        if (c) begin
          m_state = 2; m_hold = 0;
        end else if (y == 1) begin
          m_state = 3; m_hold = 0; m_level = (m_level + 1) % 100;
        end
      end
      default: if (f) begin
        if (m_hold + 1 == 60) begin
          if (m_state == 2) m_level = 0;
          m_state = 1; m_prst = 1; m_frames = 0;
        end else begin
          m_hold++;
        end
      end
    endcase
    m_freeze = (m_state != 1) ? 1 : 0;
    m_flash  = (m_state >= 2) ? (m_hold / 8) % 2 : 0;
  endtask

  // One clock cycle: drive inputs, advance the model, compare all outputs.
  task automatic cyc(input bit r, input bit f, input bit s, input int y, input bit c);
    rst_n = r; fs = f; st = s; py = 4'(y); col = c;
    @(posedge clk);
    model_step(r, f, s, y, c);
    #1;
    chk("m_state",  int'(o_state),        m_state);
    chk("m_level",  int'(o_level),        m_level);
    chk("m_preset", int'(o_player_reset), m_prst);
    chk("m_freeze", int'(o_freeze),       m_freeze);
    chk("m_tick",   int'(o_move_tick),    m_tick);
    chk("m_flash",  int'(o_flash),        m_flash);
  endtask

  task automatic win_once();
    cyc(1, 0, 0, 1, 0);
    repeat (60) cyc(1, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
  endtask

  typedef struct {
    bit r, f, s, c;
    int y;
    int e_state, e_level, e_prst, e_freeze;
  } vec_t;

  vec_t tbl[16];

  initial begin
    int ticks, tick_ok, pulses;
    bit r, f, s, c;
    int y;

    tbl[0]  = '{1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 0, 0, 1};
    tbl[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 0, 0, 1};
    tbl[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 0, 0, 0, 0, 1};
    tbl[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, 0, 0, 0, 0, 1};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 0, 0, 0, 0, 1};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 0, 0, 0, 0, 1};
    tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 0, 0, 0, 0, 1};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 1};
    tbl[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 0, 1, 0, 1, 0};
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 0, 1, 0, 0, 0};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1, 3, 1, 0, 1};
    tbl[11] = '{1'b1, 1'b0, 1'b1, 1'b1, 0, 3, 1, 0, 1};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 1};
    tbl[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 1};
    tbl[14] = '{1'b1, 1'b0, 1'b1, 1'b0, 0, 1, 0, 1, 0};
    tbl[15] = '{1'b1, 1'b0, 1'b0, 1'b1, 1, 2, 0, 0, 1};

    // Vector table: reset with start held, start edge, win, reset, priority.
    for (int i = 0; i < 16; i++) begin
      cyc(tbl[i].r, tbl[i].f, tbl[i].s, tbl[i].y, tbl[i].c);
      chk($sformatf("vec%0d_state", i),  int'(o_state),        tbl[i].e_state);
      chk($sformatf("vec%0d_level", i),  int'(o_level),        tbl[i].e_level);
      chk($sformatf("vec%0d_preset", i), int'(o_player_reset), tbl[i].e_prst);
      chk($sformatf("vec%0d_freeze", i), int'(o_freeze),       tbl[i].e_freeze);
    end

    // Level 0: 24 frame pulses give ticks right after frames 12 and 24.
    cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 1, 0, 0);
    chk("play_entry", int'(o_state), 1);
    ticks = 0; tick_ok = 0;
    for (int i = 1; i <= 24; i++) begin
      cyc(1, 1, 0, 0, 0);
      if (o_move_tick) begin
        ticks++;
        if (i == 12 || i == 24) tick_ok++;
      end
      cyc(1, 0, 0, 0, 0);
      if (o_move_tick) ticks++;
    end
    chk("ticks_level0", ticks, 2);
    chk("tick_timing", tick_ok, 2);

    // Win: level increments, 60 frames of hold, single player reset.
    cyc(1, 0, 0, 1, 0);
    chk("win_state", int'(o_state), 3);
    chk("win_level", int'(o_level), 1);
    pulses = 0;
    for (int i = 1; i <= 60; i++) begin
      cyc(1, 1, 0, 0, 0);
      if (o_player_reset) pulses++;
      if (i == 59) chk("win_hold59", int'(o_state), 3);
    end
    chk("win_exit_state", int'(o_state), 1);
    chk("win_exit_preset", int'(o_player_reset), 1);
    cyc(1, 0, 0, 0, 0);
    chk("preset_one_cycle", int'(o_player_reset), 0);
    chk("preset_pulses", pulses, 1);

    // Level 8: divider 11.
    repeat (7) win_once();
    chk("level8", int'(o_level), 8);
    ticks = 0;
    repeat (22) begin
      cyc(1, 1, 0, 0, 0);
      if (o_move_tick) ticks++;
    end
    chk("ticks_level8", ticks, 2);

    // Level 96: divider clamps to 2.
    repeat (88) win_once();
    chk("level96", int'(o_level), 96);
    ticks = 0;
    repeat (10) begin
      cyc(1, 1, 0, 0, 0);
      if (o_move_tick) ticks++;
    end
    chk("ticks_level96", ticks, 5);

    // Level wrap 99 -> 0.
    repeat (3) win_once();
    chk("level99", int'(o_level), 99);
    cyc(1, 0, 0, 1, 0);
    chk("wrap_level", int'(o_level), 0);
    repeat (60) cyc(1, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);

    // Collision beats goal at level 5; HIT exit zeroes level.
    repeat (5) win_once();
    cyc(1, 0, 0, 1, 1);
    chk("hit_state", int'(o_state), 2);
    chk("hit_level", int'(o_level), 5);
    repeat (60) cyc(1, 1, 0, 0, 1);
    chk("hit_exit_state", int'(o_state), 1);
    chk("hit_exit_level", int'(o_level), 0);
    chk("hit_exit_preset", int'(o_player_reset), 1);

    // Reset in the middle of HIT.
    cyc(1, 0, 0, 0, 1);
    repeat (30) cyc(1, 1, 0, 0, 1);
    chk("midhit_state", int'(o_state), 2);
    chk("midhit_flash", int'(o_flash), 1);
    cyc(0, 0, 0, 0, 0);
    chk("rst_state", int'(o_state), 0);
    chk("rst_level", int'(o_level), 0);
    chk("rst_flash", int'(o_flash), 0);
    chk("rst_preset", int'(o_player_reset), 0);

    // Randomized run against the model.
    s = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 299) != 0);
      f = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 9) == 0) s = ~s;
      c = ($urandom_range(0, 40) == 0);
      y = ($urandom_range(0, 30) == 0) ? 1 : int'($urandom_range(0, 15));
      cyc(r, f, s, y, c);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
